// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: preset/run/pause/alarm sequencing over a 0..MAX_COUNT
// count, with an internal tick prescaler and two registered seven-segment digit drivers.
module countdown_timer_ctrl #(
  parameter int unsigned TICK_DIV    = 12_000_000,
  parameter int unsigned MAX_COUNT   = 59,
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [8:0] seg_led_1,
  output logic [8:0] seg_led_2,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ALM_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_COUNT);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_TICKS - 1);
  localparam logic [8:0]       SEG_ZERO = 9'h03F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [PRE_W-1:0] prescaler;
  logic [ALM_W-1:0] alarm_cnt;

  logic             tick;
  logic [CNT_W-1:0] preset_up;
  logic [CNT_W-1:0] preset_dn;
  logic [3:0]       tens;
  logic [3:0]       ones;

  // Prescaler only counts while timing; tick marks its last cycle.
  assign tick = ((state == RUN) || (state == DONE)) && (prescaler == PRE_LAST);

  // Wrap is decided by comparison first, so the preset never leaves 0..MAX_COUNT.
  assign preset_up = (preset == MAX_VAL) ? '0 : preset + CNT_W'(1);
  assign preset_dn = (preset == '0) ? MAX_VAL : preset - CNT_W'(1);

  // Digits come straight from the live count, so the display lags count by one edge.
  assign tens = 4'(count / CNT_W'(10));
  assign ones = 4'(count % CNT_W'(10));

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  // State, datapath and registered outputs; running/alarm follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      preset    <= '0;
      count     <= '0;
      prescaler <= '0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      seg_led_1 <= SEG_ZERO;
      seg_led_2 <= SEG_ZERO;
    end else begin
      seg_led_1 <= {2'b00, seg7(tens)};
      seg_led_2 <= {2'b00, seg7(ones)};

      if ((state == RUN) || (state == DONE)) begin
        prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      end else begin
        prescaler <= '0;
      end

      case (state)
        IDLE: begin
          if (key_start && (preset != '0)) begin
            state     <= RUN;
            running   <= 1'b1;
            count     <= preset;
            prescaler <= '0;
          end else if (key_inc) begin
            preset <= preset_up;
            count  <= preset_up;
          end else if (key_dec) begin
            preset <= preset_dn;
            count  <= preset_dn;
          end else begin
            count <= preset;
          end
        end

        RUN: begin
          // The final tick takes priority over a coincident pause request.
          if (tick && (count == CNT_W'(1))) begin
            state     <= DONE;
            running   <= 1'b0;
            alarm     <= 1'b1;
            count     <= '0;
            prescaler <= '0;
            alarm_cnt <= '0;
          end else if (key_start) begin
            state     <= PAUSE;
            running   <= 1'b0;
            prescaler <= '0;
          end else if (tick) begin
            count <= count - CNT_W'(1);
          end
        end

        PAUSE: begin
          if (key_start) begin
            state     <= RUN;
            running   <= 1'b1;
            prescaler <= '0;
          end else if (key_inc || key_dec) begin
            state <= IDLE;
            count <= preset;
          end
        end

        DONE: begin
          count <= '0;
          if (key_start || (tick && (alarm_cnt == ALM_LAST))) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            count     <= preset;
            alarm_cnt <= '0;
          end else if (tick) begin
            alarm_cnt <= alarm_cnt + ALM_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          running   <= 1'b0;
          alarm     <= 1'b0;
          count     <= preset;
          alarm_cnt <= '0;
        end
      endcase
    end
  end

endmodule
